// File: rtl/spi_tap_loader.sv
// SPI (mode 0, MSB first) writer for the FIR tap memory: oversamples the SPI pins on clk,
// assembles 20-bit {address, coefficient} frames and issues one load strobe per accepted frame.
module spi_tap_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 12,
  parameter int NUM_TAPS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_value,
  output logic              load,
  output logic              busy,
  output logic              frame_err,
  output logic [5:0]        load_count
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   TAP_LIM  = (ADDR_W + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bitcnt;
  logic               clr, shift_en, accept, reject;
  logic               addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign busy      = ~cs_s;

  assign addr_ok = {1'b0, shreg[FRAME_W-1:DATA_W]} < TAP_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A same-cycle sclk rise and cs_n rise both act: the shift lands before COMMIT evaluates.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          clr       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise;
        if (cs_rise) state_nxt = COMMIT;
      end
      COMMIT: begin
        if (bitcnt == CNT_FULL && addr_ok) accept = 1'b1;
        else                               reject = 1'b1;
        clr       = cs_fall;
        state_nxt = cs_fall ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg         <= '0;
      bitcnt        <= '0;
      write_address <= '0;
      write_value   <= '0;
      load          <= 1'b0;
      frame_err     <= 1'b0;
      load_count    <= '0;
    end else begin
      if (clr) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[FRAME_W-2:0], mosi_s};
        if (bitcnt != CNT_SAT) bitcnt <= bitcnt + 1'b1;
      end
      load      <= accept;
      frame_err <= reject;
      if (accept) begin
        write_address <= shreg[FRAME_W-1:DATA_W];
        write_value   <= shreg[DATA_W-1:0];
        load_count    <= load_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_tap_loader.sv
// Scoreboard bench for spi_tap_loader: frames push expected load/frame_err events,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_spi_tap_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  write_address;
  logic [11:0] write_value;
  logic        load, busy, frame_err;
  logic [5:0]  load_count;

  typedef struct {
    bit          err;
    logic [7:0]  addr;
    logic [11:0] val;
    logic [5:0]  cnt;
  } ev_t;

  ev_t exq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_loads = 0;
  int exp_loads = 0;
  logic [7:0]  m_addr = '0;
  logic [11:0] m_val  = '0;
  logic [5:0]  m_cnt  = '0;

  spi_tap_loader #(
    .ADDR_W(8), .DATA_W(12), .NUM_TAPS(32), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .write_address(write_address), .write_value(write_value),
    .load(load), .busy(busy), .frame_err(frame_err), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (load || frame_err)) begin
      if (load) n_loads++;
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got load=%0b frame_err=%0b required none at %0t",
                 load, frame_err, $time);
      end else begin
        e = exq.pop_front();
        chk("strobe_kind", {30'd0, load, frame_err}, e.err ? 32'd1 : 32'd2);
        chk("write_address", {24'd0, write_address}, {24'd0, e.addr});
        chk("write_value", {20'd0, write_value}, {20'd0, e.val});
        chk("load_count", {26'd0, load_count}, {26'd0, e.cnt});
      end
    end
  end

  // All delays are multiples of 10 ns so inputs change on clk falling edges.
  task automatic frame(input logic [31:0] w, input int n, input int gap);
    ev_t e;
    bit ok;
    cs_n = 1'b0;
    #40;
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    #40;
    ok = (n == 20) && (w[19:12] < 8'd32);
    if (ok) begin
      m_addr = w[19:12];
      m_val  = w[11:0];
      m_cnt  = m_cnt + 6'd1;
      exp_loads++;
    end
    e.err = !ok; e.addr = m_addr; e.val = m_val; e.cnt = m_cnt;
    exq.push_back(e);
    cs_n = 1'b1;
    #(gap);
  endtask

  task automatic model_reset();
    m_addr = '0; m_val = '0; m_cnt = '0;
  endtask

  initial begin
    logic [31:0] w;
    // Reset with the SPI pins toggling
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk; mosi = ~mosi; cs_n = ~cs_n;
      #20;
    end
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #20;
    chk("rst_write_address", {24'd0, write_address}, 32'd0);
    chk("rst_write_value", {20'd0, write_value}, 32'd0);
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_load_count", {26'd0, load_count}, 32'd0);
    rst_n = 1'b1;
    #200;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single write 0x05 / 0xABC
    frame(32'h05ABC, 20, 200);
    chk("single_count", {26'd0, load_count}, 32'd1);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);

    // Sweep all 32 taps at the minimum cs_n gap
    for (int i = 0; i < 32; i++) begin
      w = {12'd0, 8'(i), 12'h100 + 12'(i)};
      frame(w, 20, (i == 31) ? 200 : 50);
    end
    chk("sweep_count", {26'd0, load_count}, 32'd33);

    // Rejects, each after a valid 0x1F/0x7FF write
    frame(32'h1F7FF, 20, 100);
    frame(32'h12345, 19, 100);
    frame(32'h1F7FF, 20, 100);
    frame(32'h105001, 21, 100);
    frame(32'h1F7FF, 20, 100);
    frame(32'h20123, 20, 100);
    frame(32'h1F7FF, 20, 100);
    frame(32'hFF456, 20, 200);
    chk("reject_count", {26'd0, load_count}, 32'd37);
    chk("reject_hold_addr", {24'd0, write_address}, 32'h1F);
    chk("reject_hold_val", {20'd0, write_value}, 32'h7FF);

    // Counter wrap from a clean reset
    rst_n = 1'b0;
    model_reset();
    #20 rst_n = 1'b1;
    #100;
    for (int i = 0; i < 64; i++) begin
      w = {12'd0, 8'(i % 32), 12'h200 + 12'(i)};
      frame(w, 20, (i == 63) ? 200 : 50);
    end
    chk("wrap_count", {26'd0, load_count}, 32'd0);

    // Reset after 10 bits of a frame, then a clean 0x03/0x123 write
    w = 32'h1F7FF;
    cs_n = 1'b0;
    #40;
    for (int i = 19; i >= 10; i--) begin
      mosi = w[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
    #20 cs_n = 1'b1;
    #50;
    rst_n = 1'b1;
    #200;
    chk("midrst_count", {26'd0, load_count}, 32'd0);
    frame(32'h03123, 20, 200);

    #500;
    chk("queue_drained", exq.size(), 32'd0);
    chk("load_total", n_loads, exp_loads);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
